// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg: shared FSM states, default width and result record for pulse_meas
package pulse_meas_pkg;
  localparam int PM_W_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} pm_state_e;
  typedef struct packed {
    logic [PM_W_DEFAULT-1:0] high;
    logic [PM_W_DEFAULT-1:0] period;
    logic                    sat;
  } pm_rec_t;
endpackage

// File: rtl/pulse_meas_if.sv
// pulse_meas_if: strobe inputs and result handshake; timeout exists only with PULSE_MEAS_TIMEOUT_EN
interface pulse_meas_if import pulse_meas_pkg::*; #(parameter int W = PM_W_DEFAULT);
  logic         rise, fall, clr, out_ready;
  logic         out_valid, out_sat, overrun, err;
  logic [W-1:0] out_high, out_period;
`ifdef PULSE_MEAS_TIMEOUT_EN
  logic         timeout;
  modport master (output rise, fall, clr, out_ready,
                  input out_valid, out_high, out_period, out_sat, overrun, err, timeout);
  modport slave (input rise, fall, clr, out_ready,
                 output out_valid, out_high, out_period, out_sat, overrun, err, timeout);
`else
  modport master (output rise, fall, clr, out_ready,
                  input out_valid, out_high, out_period, out_sat, overrun, err);
  modport slave (input rise, fall, clr, out_ready,
                 output out_valid, out_high, out_period, out_sat, overrun, err);
`endif
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter with load-to-1, increment enable and saturation at all-ones
module sat_counter import pulse_meas_pkg::*; #(parameter int W = PM_W_DEFAULT) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_max_o = &cnt_q;
  assign cnt_o = cnt_q;
  always_comb cnt_d = load_i ? W'(1) : (inc_i && !at_max_o) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pulse_meas.sv
// pulse_meas: high-time/period measurement from rise/fall strobes with a one-entry result register.
// PULSE_MEAS_TIMEOUT_EN turns period saturation into an abort back to IDLE with a timeout pulse.
module pulse_meas import pulse_meas_pkg::*; #(parameter int W = PM_W_DEFAULT) (
  input logic        clk,
  input logic        rst,
  pulse_meas_if.slave p
);
  typedef struct packed {
    logic [W-1:0] high;
    logic [W-1:0] period;
    logic         sat;
  } rec_t;
  pm_state_e    state_q, state_d;
  rec_t         rec_q, rec_d;
  logic [W-1:0] hcnt, pcnt, hi_cap_q, hi_cap_d;
  logic h_max, p_max, sat_q, sat_d, valid_q, valid_d, overrun_q, overrun_d, err_q, err_d;
  logic rise_only, fall_only, both, run, tmo, rec_sat, load, h_inc, p_inc, emit, take, err_set;
  assign rise_only = p.rise & ~p.fall;
  assign fall_only = p.fall & ~p.rise;
  assign both = p.rise & p.fall;
  assign run = state_q != IDLE;
`ifdef PULSE_MEAS_TIMEOUT_EN
  logic tmo_q;
  assign tmo = run & p_max;
  assign rec_sat = 1'b0;
  assign p.timeout = tmo_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= 1'b0;
    else tmo_q <= tmo;
`else
  assign tmo = 1'b0;
  assign rec_sat = sat_q | h_max | p_max;
`endif
  // a simultaneous rise+fall is ignored but time still passes, so counters keep advancing
  assign load = rise_only & ~tmo;
  assign h_inc = (state_q == HIGH) & ~(p.rise ^ p.fall);
  assign p_inc = run & ~rise_only;
  assign emit = (state_q == LOW) & rise_only & ~tmo;
  assign take = emit & (~valid_q | p.out_ready);
  assign err_set = both | ((state_q == HIGH) & rise_only) | ((state_q == LOW) & fall_only);
  sat_counter #(.W(W)) u_hcnt (.clk(clk), .rst(rst), .load_i(load), .inc_i(h_inc), .cnt_o(hcnt), .at_max_o(h_max));
  sat_counter #(.W(W)) u_pcnt (.clk(clk), .rst(rst), .load_i(load), .inc_i(p_inc), .cnt_o(pcnt), .at_max_o(p_max));
  always_comb begin
    state_d = tmo ? IDLE : rise_only ? HIGH : (fall_only && state_q == HIGH) ? LOW : state_q;
    sat_d = rise_only ? 1'b0 : sat_q | (run & (h_max | p_max));
    hi_cap_d = (state_q == HIGH && fall_only) ? hcnt : hi_cap_q;
    valid_d = take | (valid_q & ~p.out_ready);
    rec_d = take ? {hi_cap_q, pcnt, rec_sat} : rec_q;
    overrun_d = (emit & valid_q & ~p.out_ready) | (overrun_q & ~p.clr);
    err_d = err_set | (err_q & ~p.clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rec_q <= '0;
      hi_cap_q <= '0;
      sat_q <= 1'b0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q <= rec_d;
      hi_cap_q <= hi_cap_d;
      sat_q <= sat_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      err_q <= err_d;
    end
  assign p.out_valid = valid_q;
  assign p.out_high = rec_q.high;
  assign p.out_period = rec_q.period;
  assign p.out_sat = rec_q.sat;
  assign p.overrun = overrun_q;
  assign p.err = err_q;
endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas: directed table and corner sequences for pulse_meas at W=16 and W=4
module tb_pulse_meas;
  import pulse_meas_pkg::*;
  typedef struct {
    logic    r, f, ev;
    pm_rec_t exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic rise = 1'b0, fall = 1'b0, clr = 1'b0, out_ready = 1'b1;
  int n_cmp = 0, n_bad = 0, n_tmo = 0;
  vec_t tbl [14];
  pulse_meas_if #(.W(16)) b16 ();
  pulse_meas_if #(.W(4)) b4 ();
  assign b16.rise = rise;
  assign b16.fall = fall;
  assign b16.clr = clr;
  assign b16.out_ready = out_ready;
  assign b4.rise = rise;
  assign b4.fall = fall;
  assign b4.clr = clr;
  assign b4.out_ready = out_ready;
  pulse_meas #(.W(16)) dut16 (.clk(clk), .rst(rst), .p(b16.slave));
  pulse_meas #(.W(4)) dut4 (.clk(clk), .rst(rst), .p(b4.slave));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f);
    rise = r;
    fall = f;
    @(posedge clk);
    #1;
    rise = 1'b0;
    fall = 1'b0;
`ifdef PULSE_MEAS_TIMEOUT_EN
    if (b4.timeout) n_tmo++;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_res(input string nm, input logic v, input logic [15:0] h, input logic [15:0] per);
    chk({nm, ".valid"}, b16.out_valid, v);
    chk({nm, ".high"}, b16.out_high, h);
    chk({nm, ".period"}, b16.out_period, per);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b0, 1'b0, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b0, 1'b1, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b0, 1'b0, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b1, 1'b0, 1'b1, '{16'd2, 16'd4, 1'b0}},
      '{1'b0, 1'b0, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b0, 1'b1, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b0, 1'b0, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b1, 1'b0, 1'b1, '{16'd2, 16'd4, 1'b0}},
      '{1'b0, 1'b1, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b1, 1'b0, 1'b1, '{16'd1, 16'd2, 1'b0}},
      '{1'b0, 1'b1, 1'b0, '{16'd0, 16'd0, 1'b0}},
      '{1'b1, 1'b0, 1'b1, '{16'd1, 16'd2, 1'b0}},
      '{1'b0, 1'b0, 1'b0, '{16'd0, 16'd0, 1'b0}}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", b16.out_valid, 1'b0);
    chk("rst.high", b16.out_high, 16'd0);
    chk("rst.period", b16.out_period, 16'd0);
    chk("rst.sat", b16.out_sat, 1'b0);
    chk("rst.overrun", b16.overrun, 1'b0);
    chk("rst.err", b16.err, 1'b0);
    rst = 1'b0;

    // basic measurement and minimum period back to back
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].f);
      chk($sformatf("tbl%0d.valid", i), b16.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.valid4", i), b4.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.err", i), b16.err, 1'b0);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.high", i), b16.out_high, tbl[i].exp.high);
        chk($sformatf("tbl%0d.period", i), b16.out_period, tbl[i].exp.period);
        chk($sformatf("tbl%0d.sat", i), b16.out_sat, tbl[i].exp.sat);
        chk($sformatf("tbl%0d.high4", i), b4.out_high, tbl[i].exp.high);
      end
    end

    // backpressure: second result dropped, first held
    do_reset();
    out_ready = 1'b0;
    cyc(1'b1, 1'b0); idle(1); cyc(1'b0, 1'b1); idle(1); cyc(1'b1, 1'b0);
    chk_res("bp.first", 1'b1, 16'd2, 16'd4);
    idle(2); cyc(1'b0, 1'b1); idle(1); cyc(1'b1, 1'b0);
    chk_res("bp.held", 1'b1, 16'd2, 16'd4);
    chk("bp.overrun", b16.overrun, 1'b1);
    chk("bp.err", b16.err, 1'b0);
    clr = 1'b1;
    cyc(1'b0, 1'b0);
    clr = 1'b0;
    chk("bp.clr_overrun", b16.overrun, 1'b0);
    chk("bp.still_valid", b16.out_valid, 1'b1);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0);
    chk("bp.drained", b16.out_valid, 1'b0);

    // protocol errors
    do_reset();
    cyc(1'b1, 1'b0); idle(1); cyc(1'b1, 1'b0);
    chk("pe.rise_rise_err", b16.err, 1'b1);
    chk("pe.rise_rise_valid", b16.out_valid, 1'b0);
    cyc(1'b0, 1'b1); cyc(1'b1, 1'b1);
    chk("pe.both_valid", b16.out_valid, 1'b0);
    clr = 1'b1;
    cyc(1'b0, 1'b0);
    clr = 1'b0;
    chk("pe.clr_err", b16.err, 1'b0);
    cyc(1'b1, 1'b0);
    chk_res("pe.after_both", 1'b1, 16'd1, 16'd4);
    idle(2); cyc(1'b0, 1'b1); idle(2); cyc(1'b1, 1'b0);
    chk_res("pe.clean", 1'b1, 16'd3, 16'd6);
    chk("pe.clean_err", b16.err, 1'b0);
    clr = 1'b1;
    cyc(1'b1, 1'b1);
    clr = 1'b0;
    chk("pe.set_beats_clr", b16.err, 1'b1);

    // saturation: 20-cycle high, 24-cycle period
    do_reset();
    n_tmo = 0;
    cyc(1'b1, 1'b0); idle(19); cyc(1'b0, 1'b1); idle(3); cyc(1'b1, 1'b0);
    chk_res("sat.w16", 1'b1, 16'd20, 16'd24);
    chk("sat.w16_sat", b16.out_sat, 1'b0);
`ifdef PULSE_MEAS_TIMEOUT_EN
    chk("sat.w4_timeouts", n_tmo, 1);
    chk("sat.w4_valid", b4.out_valid, 1'b0);
`else
    chk("sat.w4_valid", b4.out_valid, 1'b1);
    chk("sat.w4_high", b4.out_high, 4'd15);
    chk("sat.w4_period", b4.out_period, 4'd15);
    chk("sat.w4_sat", b4.out_sat, 1'b1);
`endif

    // reset mid-measurement
    do_reset();
    out_ready = 1'b0;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1); cyc(1'b1, 1'b0);
    chk_res("rm.pre", 1'b1, 16'd1, 16'd2);
    cyc(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_res("rm.async", 1'b0, 16'd0, 16'd0);
    chk("rm.async4", b4.out_valid, 1'b0);
    chk("rm.async_sat", b16.out_sat, 1'b0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    cyc(1'b1, 1'b0);
    chk("rm.first_edge_err", b16.err, 1'b0);
    chk("rm.first_edge_valid", b16.out_valid, 1'b0);
    idle(1); cyc(1'b0, 1'b1); idle(1);
    chk("rm.partial_valid", b16.out_valid, 1'b0);
    cyc(1'b1, 1'b0);
    chk_res("rm.result", 1'b1, 16'd2, 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_meas.md
# pulse_meas

Measures high time and period of a digital signal from single-cycle `rise` and `fall` strobes produced by the upstream edge detector. Results are delivered as one record per complete cycle (rise → fall → rise) over a valid/ready output handshake. Sits directly downstream of the edge detector and feeds timing data to control or logging logic. Protocol anomalies and dropped results are reported via sticky flags.

## Interface
- `W`, default 16: counter and result width in cycles.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rise`  in  1  single-cycle rising-edge strobe from the edge detector.
- `fall`  in  1  single-cycle falling-edge strobe from the edge detector.
- `clr`  in  1  synchronous clear of `overrun` and `err`.
- `out_ready`  in  1  consumer accepts the result.
- `out_valid`  out  1  result held and valid.
- `out_high`  out  W  high time in clk cycles.
- `out_period`  out  W  period in clk cycles.
- `out_sat`  out  1  a counter saturated during this measurement.
- `overrun`  out  1  sticky: a result was dropped.
- `err`  out  1  sticky: protocol violation.
- `timeout`  out  1  single-cycle pulse on abort; only exists with `PULSE_MEAS_TIMEOUT_EN`.

## Operation
- States: IDLE, HIGH, LOW.
- IDLE: ignore `fall`. On `rise` → HIGH, with `hcnt` = 1, `pcnt` = 1, `sat` = 0.
- HIGH, each cycle with no strobe: `hcnt`++ and `pcnt`++.
  - On `fall`: `hi_cap` ← `hcnt`, `pcnt`++, → LOW.
- LOW, each cycle with no strobe: `pcnt`++.
  - On `rise`: emit the result {`hi_cap`, `pcnt`, `sat`}, reload `hcnt` = `pcnt` = 1, clear `sat`, → HIGH.
- Anomalies:
  - `rise` in HIGH (missed fall): `err` ← 1, restart HIGH with counts = 1, no result.
  - `fall` in LOW: `err` ← 1, ignored.
  - `rise` and `fall` asserted in the same cycle: `err` ← 1, both ignored, counters still advance.
- Saturation: `hcnt` and `pcnt` stop at 2^W−1. Reaching 2^W−1 sets `sat`.
- Output register, one entry:
  - Emit when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1: load the record, `out_valid` ← 1.
  - Emit when `out_valid`=1 and `out_ready`=0: the held result is kept, the new result is dropped, `overrun` ← 1.
  - `out_valid`=1 and `out_ready`=1 with no emit: `out_valid` ← 0.
- `clr` clears `overrun` and `err`. A set condition in the same cycle as `clr` wins.
- Reset values: state IDLE; all counters 0; `out_valid`, `out_high`, `out_period`, `out_sat`, `overrun`, `err`, `timeout` all 0.
- Reset asserted mid-measurement discards all partial data.

## Timing
- Counts are strobe-to-strobe distances in cycles. Example: rise at cycle t, fall at t+2, rise at t+4 → `out_high`=2, `out_period`=4.
- Latency: `out_valid` rises in the cycle after the closing `rise` strobe.
- Sustained throughput is one result per period ≥ 2 with `out_ready` held high.
- Output fields are stable while `out_valid`=1 and `out_ready`=0.
- Minimum legal period is 2: rise, fall, rise on consecutive cycles gives high=1, period=2.

## Configuration
- `PULSE_MEAS_TIMEOUT_EN` defined:
  - When `pcnt` reaches 2^W−1 in HIGH or LOW, the FSM returns to IDLE and pulses `timeout` for one cycle.
  - No result is emitted; `out_sat` is never set.
- Macro undefined:
  - The `timeout` port is absent.
  - Counters saturate and hold; the next completed result carries `out_sat`=1.

## Structure
- Package `pulse_meas_pkg` holds:
  - the state enum {IDLE, HIGH, LOW};
  - the default width constant `PM_W_DEFAULT`=16;
  - the result record typedef {high, period, sat}.
- Sub-module `sat_counter`: W-bit counter with load-to-1, increment enable, saturate at all-ones, and an `at_max` flag. Instantiated twice, for `hcnt` and `pcnt`.
- The FSM and output register live in the top module.

## Test plan
- Basic measurement:
  - Stimulus: rise at cycle 0, fall at 2, rise at 4, fall at 6, rise at 8; `out_ready`=1.
  - Response: two results {high 2, period 4}, each with `out_valid` one cycle after the closing rise.
- Backpressure:
  - Stimulus: `out_ready`=0 across two completed periods.
  - Response: the first result is held unchanged, the second is dropped, `overrun`=1. Pulsing `clr` returns `overrun` to 0.
- Protocol errors:
  - Stimulus: rise then rise with no fall; `rise` and `fall` in the same cycle.
  - Response: `err`=1, no result emitted, the next clean cycle measures correctly.
- Saturation with W=4, macro off:
  - Stimulus: high time 20 cycles, then a complete cycle.
  - Response: `out_high`=15, `out_sat`=1.
  - With the macro on: `timeout` pulses once, FSM returns to IDLE, no result.
- Reset mid-measurement:
  - Stimulus: assert `rst` while in HIGH with `out_valid`=1.
  - Response: all outputs are 0 immediately. The next rise is treated as the first edge; the first result appears after a full cycle.
